tspp_fetch_stage: RTL

- Fetch stage of the two-stage pipeline; directly upstream of the execute stage and feeds its fetch/execute latch.
- Owns the PC and drives the instruction-memory side of the generic bus with a ren/busy handshake.
- Provides a one-entry skid buffer so a completed fetch is never lost while execute stalls.
- Handles redirects from execute, including redirects that arrive mid-transaction.
- Uses word_t from rv32i_types_pkg, which is imported through tspp_types_pkg.

---
 rtl/tspp_fetch_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/tspp_fetch_stage.sv
// tspp_fetch_stage: PC owner and instruction fetch for the two-stage pipeline,
// with a one-entry skid buffer and redirect handling across bus transactions.
package rv32i_types_pkg;
    typedef logic [31:0] word_t;
endpackage

package tspp_types_pkg;
    typedef rv32i_types_pkg::word_t word_t;
endpackage

module tspp_fetch_stage
    import tspp_types_pkg::*;
#(
    parameter word_t RESET_PC  = 32'h0000_0200,
    parameter word_t NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_busy,
    input  logic        ex_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc4,
    output logic        fetch_misaligned
);
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0] state_q, state_d;
    word_t pc_q, pc_d, tgt_q, tgt_d;
    word_t fi_q, fi_d, fpc_q, fpc_d, si_q, si_d, spc_q, spc_d;
    logic discard_q, discard_d, fv_q, fv_d, fmis_q, fmis_d, sv_q, sv_d;
    logic consume, accept;

    assign imem_ren  = (state_q == S_REQ) && !RST;
    assign imem_addr = pc_q;
    // A fault entry is sticky: only a redirect clears it.
    assign consume   = fv_q && !ex_stall && !fmis_q;
    assign accept    = !fv_q || consume;

    assign fetch_valid      = fv_q;
    assign fetch_instr      = fi_q;
    assign fetch_pc         = fpc_q;
    assign fetch_pc4        = fpc_q + 32'd4;
    assign fetch_misaligned = fmis_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        discard_d = discard_q;
        fv_d      = fv_q;
        fi_d      = fi_q;
        fpc_d     = fpc_q;
        fmis_d    = fmis_q;
        sv_d      = sv_q;
        si_d      = si_q;
        spc_d     = spc_q;
        if (redirect_valid) begin
            fv_d   = 1'b0;
            fi_d   = NOP_INSTR;
            fmis_d = 1'b0;
            sv_d   = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                fv_d   = 1'b1;
                fmis_d = 1'b1;
                fpc_d  = redirect_pc;
            end
            // The bus address must not move mid-transaction, so park the target.
            if (state_q == S_REQ && imem_busy) begin
                discard_d = 1'b1;
                tgt_d     = redirect_pc;
            end else begin
                discard_d = 1'b0;
                pc_d      = redirect_pc;
                state_d   = (redirect_pc[1:0] != 2'b00) ? S_HALT : S_REQ;
            end
        end else if (state_q == S_REQ) begin
            if (consume) begin
                fv_d = 1'b0;
                fi_d = NOP_INSTR;
            end
            if (!imem_busy) begin
                if (discard_q) begin
                    discard_d = 1'b0;
                    pc_d      = tgt_q;
                    state_d   = (tgt_q[1:0] != 2'b00) ? S_HALT : S_REQ;
                end else if (accept) begin
                    fv_d  = 1'b1;
                    fi_d  = imem_rdata;
                    fpc_d = pc_q;
                    pc_d  = pc_q + 32'd4;
                end else begin
                    sv_d    = 1'b1;
                    si_d    = imem_rdata;
                    spc_d   = pc_q;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_HOLD;
                end
            end
        end else if (state_q == S_HOLD && consume) begin
            fv_d    = sv_q;
            fi_d    = si_q;
            fpc_d   = spc_q;
            sv_d    = 1'b0;
            state_d = S_REQ;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            tgt_q     <= '0;
            discard_q <= 1'b0;
            fv_q      <= 1'b0;
            fi_q      <= NOP_INSTR;
            fpc_q     <= '0;
            fmis_q    <= 1'b0;
            sv_q      <= 1'b0;
            si_q      <= NOP_INSTR;
            spc_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            tgt_q     <= tgt_d;
            discard_q <= discard_d;
            fv_q      <= fv_d;
            fi_q      <= fi_d;
            fpc_q     <= fpc_d;
            fmis_q    <= fmis_d;
            sv_q      <= sv_d;
            si_q      <= si_d;
            spc_q     <= spc_d;
        end
    end
endmodule
